spring_array: RTL and testbench

- Parametrised successor to the single-spring contact detector.
- Manages NUM_SPRINGS springboards at fixed absolute map coordinates.
- Each spring runs its own compress/launch/cooldown state machine, paced by the frame tick.
- Gives the physics block a one-cycle launch pulse with strength, and the renderer per-spring compressed flags and positions.

---
 rtl/mario_obj_pkg.sv | 12 +
 rtl/spring_cell.sv | 71 +++++++
 rtl/spring_array.sv | 122 ++++++++++++
 tb/tb_spring_array.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mario_obj_pkg.sv
// Shared definitions for map objects: spring cell states and default sprite/coordinate sizes.
package mario_obj_pkg;
  localparam int COORD_W_DEF  = 9;
  localparam int OBJ_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    LAUNCH   = 2'd2,
    COOLDOWN = 2'd3
  } spring_state_t;
endpackage

// File: rtl/spring_cell.sv
// One springboard: compress/launch/cooldown FSM with a frame-tick counter.
module spring_cell
  import mario_obj_pkg::*;
#(
  parameter int COMPRESS_TICKS = 4,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          frame_tick,
  input  logic          contact,
  input  logic          grant,
  output spring_state_t state,
  output logic          compressed,
  output logic          launch
);
  localparam int MAXT  = (COMPRESS_TICKS > COOLDOWN_TICKS) ? COMPRESS_TICKS : COOLDOWN_TICKS;
  localparam int CNT_W = (MAXT < 1) ? 1 : $clog2(MAXT + 1);

  spring_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (grant) begin
          r_state <= COMPRESS;
          r_cnt   <= '0;
        end
        // Losing contact beats a coincident frame tick.
        COMPRESS: if (!contact) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (frame_tick) begin
          if (w_cnt_nxt >= CNT_W'(COMPRESS_TICKS)) begin
            r_state <= LAUNCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        LAUNCH: begin
          r_state <= COOLDOWN;
          r_cnt   <= '0;
        end
        COOLDOWN: if (frame_tick) begin
          if (w_cnt_nxt >= CNT_W'(COOLDOWN_TICKS)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign compressed = (r_state == COMPRESS) || (r_state == LAUNCH);
  assign launch     = (r_state == LAUNCH);
endmodule

// File: rtl/spring_array.sv
// Array of springboards: contact detect, lowest-index arbitration, registered launch pulse.
// Optional macro SPRING_BOOST_EN selects HIGH_STRENGTH when jump_btn is held at launch.
module spring_array
  import mario_obj_pkg::*;
#(
  parameter int NUM_SPRINGS    = 4,
  parameter int COORD_W        = COORD_W_DEF,
  parameter int OBJ_SIZE       = OBJ_SIZE_DEF,
  parameter logic [NUM_SPRINGS*COORD_W-1:0] SPRING_X_INIT = {9'd200, 9'd150, 9'd100, 9'd50},
  parameter logic [NUM_SPRINGS*COORD_W-1:0] SPRING_Y_INIT = {4{9'd50}},
  parameter int COMPRESS_TICKS = 4,
  parameter int COOLDOWN_TICKS = 8,
  parameter logic [7:0] LOW_STRENGTH  = 8'd6,
  parameter logic [7:0] HIGH_STRENGTH = 8'd10
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             char_X,
  input  logic [COORD_W-1:0]             char_Y,
  input  logic                           char_falling,
  input  logic                           jump_btn,
  input  logic [COORD_W-1:0]             scroll_left_border,
  input  logic [COORD_W-1:0]             scroll_right_border,
  output logic [NUM_SPRINGS*COORD_W-1:0] spring_pos_X,
  output logic [NUM_SPRINGS*COORD_W-1:0] spring_pos_Y,
  output logic [NUM_SPRINGS-1:0]         spring_compressed,
  output logic                           jump,
  output logic [7:0]                     jump_strength,
  output logic [2:0]                     jump_idx
);
  // One extra bit on every sum so sprites near the map edge never wrap.
  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] SZ = CW1'(OBJ_SIZE);

  logic [CW1-1:0]         w_cx, w_cy, w_lb, w_rb;
  logic [NUM_SPRINGS-1:0] w_enable, w_contact, w_req, w_grant, w_launch, w_compressed;
  spring_state_t          w_state [NUM_SPRINGS];
  logic                   w_busy, w_any_launch;
  logic [2:0]             w_idx;
  logic [7:0]             w_str;

  logic       r_jump;
  logic [2:0] r_jump_idx;
  logic [7:0] r_jump_str;

  assign w_cx = {1'b0, char_X};
  assign w_cy = {1'b0, char_Y};
  assign w_lb = {1'b0, scroll_left_border};
  assign w_rb = {1'b0, scroll_right_border};

  assign spring_pos_X = SPRING_X_INIT;
  assign spring_pos_Y = SPRING_Y_INIT;

  for (genvar i = 0; i < NUM_SPRINGS; i++) begin : g_cell
    localparam logic [CW1-1:0] XI = {1'b0, SPRING_X_INIT[i*COORD_W +: COORD_W]};
    localparam logic [CW1-1:0] YI = {1'b0, SPRING_Y_INIT[i*COORD_W +: COORD_W]};

    assign w_enable[i]  = (XI <= w_rb) && ((XI + SZ) >= w_lb);
    assign w_contact[i] = w_enable[i] && char_falling &&
                          (w_cx < (XI + SZ)) && ((w_cx + SZ) > XI) &&
                          ((w_cy + SZ) == YI);
    assign w_req[i]     = w_contact[i] && (w_state[i] == IDLE);

    spring_cell #(
      .COMPRESS_TICKS(COMPRESS_TICKS),
      .COOLDOWN_TICKS(COOLDOWN_TICKS)
    ) u_cell (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .frame_tick(frame_tick),
      .contact   (w_contact[i]),
      .grant     (w_grant[i]),
      .state     (w_state[i]),
      .compressed(w_compressed[i]),
      .launch    (w_launch[i])
    );
  end

  // compressed covers COMPRESS and LAUNCH, which is exactly the busy set.
  assign w_busy       = |w_compressed;
  assign w_any_launch = |w_launch;

  always_comb begin
    logic found;
    found   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_SPRINGS; i++) begin
      w_grant[i] = w_req[i] && !found && !w_busy;
      found      = found | w_req[i];
      if (w_launch[i]) w_idx = 3'(i);
    end
  end

`ifdef SPRING_BOOST_EN
  assign w_str = jump_btn ? HIGH_STRENGTH : LOW_STRENGTH;
`else
  logic w_unused_btn;
  assign w_unused_btn = jump_btn;
  assign w_str        = LOW_STRENGTH;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_jump     <= 1'b0;
      r_jump_idx <= '0;
      r_jump_str <= '0;
    end else begin
      r_jump <= w_any_launch;
      if (w_any_launch) begin
        r_jump_idx <= w_idx;
        r_jump_str <= w_str;
      end
    end
  end

  assign spring_compressed = w_compressed;
  assign jump              = r_jump;
  assign jump_idx          = r_jump_idx;
  assign jump_strength     = r_jump_str;
endmodule

// File: tb/tb_spring_array.sv
// Bench for spring_array: contact vector table plus launch/abort/arbitration/reset sequences.
module tb_spring_array;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [8:0] char_X = '0, char_Y = '0, lb = '0, rb = 9'd511;
  logic       char_falling = 1'b0, jump_btn = 1'b0;

  logic [35:0] px1, py1, px2, py2;
  logic [3:0]  comp1, comp2;
  logic        jump1, jump2;
  logic [7:0]  str1, str2;
  logic [2:0]  idx1, idx2;

  int checks = 0;
  int errors = 0;

`ifdef SPRING_BOOST_EN
  localparam logic [7:0] BTN_STR = 8'd10;
`else
  localparam logic [7:0] BTN_STR = 8'd6;
`endif

  typedef struct packed {logic [2:0] idx; logic [7:0] str;} jexp_t;
  jexp_t q1[$], q2[$];
  jexp_t e1, e2;

  typedef struct {
    logic [8:0] cx, cy; logic f; logic [8:0] l, r; logic [3:0] e1, e2;
  } vec_t;
  vec_t vt[12];

  always #5 sys_clk = ~sys_clk;

  spring_array dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_tick(frame_tick),
    .char_X(char_X), .char_Y(char_Y), .char_falling(char_falling), .jump_btn(jump_btn),
    .scroll_left_border(lb), .scroll_right_border(rb),
    .spring_pos_X(px1), .spring_pos_Y(py1), .spring_compressed(comp1),
    .jump(jump1), .jump_strength(str1), .jump_idx(idx1)
  );

  spring_array #(.SPRING_X_INIT({9'd500, 9'd110, 9'd100, 9'd20})) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_tick(frame_tick),
    .char_X(char_X), .char_Y(char_Y), .char_falling(char_falling), .jump_btn(jump_btn),
    .scroll_left_border(lb), .scroll_right_border(rb),
    .spring_pos_X(px2), .spring_pos_Y(py2), .spring_compressed(comp2),
    .jump(jump2), .jump_strength(str2), .jump_idx(idx2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every jump pulse must match the next queued expectation.
  always @(negedge sys_clk) begin
    if (sys_rst_n && jump1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected jump: idx %0d expected none", idx1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 jump_idx", 64'(idx1), 64'(e1.idx));
        chk("dut1 jump_strength", 64'(str1), 64'(e1.str));
      end
    end
    if (sys_rst_n && jump2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2 unexpected jump: idx %0d expected none", idx2);
      end else begin
        e2 = q2.pop_front();
        chk("dut2 jump_idx", 64'(idx2), 64'(e2.idx));
        chk("dut2 jump_strength", 64'(str2), 64'(e2.str));
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge sys_clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n  = 1'b0;
    frame_tick = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [8:0] cx, input logic [8:0] cy, input logic f,
                        input logic [8:0] l, input logic [8:0] r);
    char_X = cx; char_Y = cy; char_falling = f; lb = l; rb = r;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 8 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge sys_clk);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s: jump pulses missing, pending %0d/%0d expected 0", nm, q1.size(), q2.size());
      q1.delete(); q2.delete();
    end
  endtask

  logic [35:0] exp_x1, exp_x2, exp_y;

  initial begin
    exp_x1 = {9'd200, 9'd150, 9'd100, 9'd50};
    exp_x2 = {9'd500, 9'd110, 9'd100, 9'd20};
    exp_y  = {4{9'd50}};
    //          cx      cy     f     l       r       e1       e2
    vt[0]  = '{9'd52,  9'd34, 1'b1, 9'd0,   9'd511, 4'b0001, 4'b0000};
    vt[1]  = '{9'd34,  9'd34, 1'b1, 9'd0,   9'd511, 4'b0000, 4'b0001};
    vt[2]  = '{9'd65,  9'd34, 1'b1, 9'd0,   9'd511, 4'b0001, 4'b0000};
    vt[3]  = '{9'd66,  9'd34, 1'b1, 9'd0,   9'd511, 4'b0000, 4'b0000};
    vt[4]  = '{9'd52,  9'd35, 1'b1, 9'd0,   9'd511, 4'b0000, 4'b0000};
    vt[5]  = '{9'd52,  9'd34, 1'b0, 9'd0,   9'd511, 4'b0000, 4'b0000};
    vt[6]  = '{9'd152, 9'd34, 1'b1, 9'd0,   9'd149, 4'b0000, 4'b0000};
    vt[7]  = '{9'd152, 9'd34, 1'b1, 9'd0,   9'd150, 4'b0100, 4'b0000};
    vt[8]  = '{9'd102, 9'd34, 1'b1, 9'd117, 9'd511, 4'b0000, 4'b0100};
    vt[9]  = '{9'd102, 9'd34, 1'b1, 9'd116, 9'd511, 4'b0010, 4'b0010};
    vt[10] = '{9'd490, 9'd34, 1'b1, 9'd400, 9'd510, 4'b0000, 4'b1000};
    vt[11] = '{9'd490, 9'd34, 1'b1, 9'd400, 9'd499, 4'b0000, 4'b0000};

    // Reset state
    cyc(2);
    chk("rst compressed", 64'(comp1), 64'd0);
    chk("rst jump", 64'(jump1), 64'd0);
    chk("rst jump_idx", 64'(idx1), 64'd0);
    chk("rst jump_strength", 64'(str1), 64'd0);
    chk("pos_X dut1", 64'(px1), 64'(exp_x1));
    chk("pos_Y dut1", 64'(py1), 64'(exp_y));
    chk("pos_X dut2", 64'(px2), 64'(exp_x2));
    sys_rst_n = 1'b1;

    // Contact/enable table: one cycle after inputs settle the granted cell is compressed
    for (int v = 0; v < 12; v++) begin
      do_reset();
      set_in(vt[v].cx, vt[v].cy, vt[v].f, vt[v].l, vt[v].r);
      cyc(2);
      chk($sformatf("vec%0d dut1 compressed", v), 64'(comp1), 64'(vt[v].e1));
      chk($sformatf("vec%0d dut2 compressed", v), 64'(comp2), 64'(vt[v].e2));
    end

    // Basic launch and cooldown on spring 0
    do_reset();
    jump_btn = 1'b1;
    set_in(9'd52, 9'd34, 1'b1, 9'd0, 9'd511);
    cyc(1);
    chk("launch compress", 64'(comp1), 64'b0001);
    for (int t = 0; t < 3; t++) tick();
    chk("launch 3 ticks still compressed", 64'(comp1), 64'b0001);
    chk("launch 3 ticks no jump", 64'(jump1), 64'd0);
    q1.push_back('{idx: 3'd0, str: BTN_STR});
    tick();
    chk("launch cycle compressed", 64'(comp1), 64'b0001);
    cyc(1);
    jump_btn = 1'b0;
    for (int t = 0; t < 7; t++) tick();
    chk("cooldown ignores contact", 64'(comp1), 64'b0000);
    tick();
    chk("cooldown exit idle", 64'(comp1), 64'b0000);
    cyc(1);
    chk("recompress after cooldown", 64'(comp1), 64'b0001);
    drain("basic launch");

    // Abort after two ticks by walking off
    do_reset();
    set_in(9'd52, 9'd34, 1'b1, 9'd0, 9'd511);
    cyc(1);
    tick(); tick();
    char_X = 9'd80;
    cyc(1);
    chk("abort compressed", 64'(comp1), 64'b0000);
    for (int t = 0; t < 4; t++) tick();
    chk("abort stays idle", 64'(comp1), 64'b0000);

    // Abort coincident with the final tick: abort wins
    do_reset();
    set_in(9'd52, 9'd34, 1'b1, 9'd0, 9'd511);
    cyc(1);
    for (int t = 0; t < 3; t++) tick();
    char_X = 9'd80;
    tick();
    chk("abort vs tick compressed", 64'(comp1), 64'b0000);
    cyc(4);

    // Arbitration: straddle springs at 100 and 110 (dut2), spring 1 of dut1 also hit
    do_reset();
    set_in(9'd105, 9'd34, 1'b1, 9'd0, 9'd511);
    cyc(1);
    chk("arb dut2 lowest grant", 64'(comp2), 64'b0010);
    for (int t = 0; t < 3; t++) tick();
    q1.push_back('{idx: 3'd1, str: 8'd6});
    q2.push_back('{idx: 3'd1, str: 8'd6});
    tick();
    chk("arb dut2 launch, spring2 idle", 64'(comp2), 64'b0010);
    chk("arb dut1 launch", 64'(comp1), 64'b0010);
    cyc(2);
    chk("arb dut2 spring2 after release", 64'(comp2), 64'b0100);
    drain("arbitration");

    // Reset during LAUNCH: no pulse, registers cleared
    do_reset();
    set_in(9'd105, 9'd34, 1'b1, 9'd0, 9'd511);
    cyc(1);
    for (int t = 0; t < 4; t++) tick();
    chk("pre-reset launch", 64'(comp1), 64'b0010);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst compressed", 64'(comp1), 64'd0);
    chk("midrst jump", 64'(jump1), 64'd0);
    chk("midrst jump_idx", 64'(idx1), 64'd0);
    chk("midrst jump_strength", 64'(str1), 64'd0);
    chk("midrst pos_X", 64'(px1), 64'(exp_x1));
    cyc(2);
    chk("midrst jump held", 64'(jump1), 64'd0);
    sys_rst_n = 1'b1;
    cyc(4);
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
